multiword_add_seq: RTL

//  Sequencer that computes a WORDS*16-bit sum with one 16-bit ripple adder

---
 rtl/multiword_add_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: drives one external 16-bit ripple adder one slice per
// clock (LS slice first), carrying between slices through a register.
module multiword_add_seq #(
   parameter int WORDS = 4            // slices per operation, 2..8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [16*WORDS-1:0]   result,
   output logic                  cout,
   output logic                  overflow,
   output logic [15:0]           adder_x,
   output logic [15:0]           adder_y,
   output logic                  adder_cin,
   input  logic [15:0]           adder_sum,
   input  logic                  adder_cout,
   output logic [1:0]            state_dbg
);

   localparam int W     = 16 * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam int BIT_W = IDX_W + 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Handshake: start is sampled only in IDLE or DONE; a start seen while busy is
   // dropped. done is a one-cycle pulse that marks result/cout/overflow valid, and
   // those outputs hold until a later operation overwrites them slice by slice.
   logic [1:0]       state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic             carry_q,  carry_d;
   logic [W-1:0]     a_q,      a_d;
   logic [W-1:0]     b_q,      b_d;
   logic [W-1:0]     result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;
   logic [BIT_W-1:0] bit_base;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      adder_x   = '0;
      adder_y   = '0;
      adder_cin = 1'b0;
      bit_base  = {idx_q, 4'b0000};

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            adder_x   = a_q[bit_base +: 16];
            adder_y   = b_q[bit_base +: 16];
            adder_cin = carry_q;
            result_d[bit_base +: 16] = adder_sum;
            carry_d   = adder_cout;
            idx_d     = idx_q + 1'b1;
            // Signed overflow only needs the top slice: operand signs and sum sign.
            if (idx_q == LAST_IDX) begin
               cout_d  = adder_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (adder_sum[15] != a_q[W-1]);
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign state_dbg = state_q;

endmodule
